// File: rtl/wb_write_arbiter.sv
// Purpose : merges unbuffered ALU results and FIFO-buffered load returns onto one register-file write port.
// Latency : the winning source appears on RegWrite/rd/Write_Data one clock after it wins arbitration.
// Backpr. : ld_ready = FIFO not full; alu_stall only asserts when WB_STARVE_GUARD_EN is defined.
module wb_write_arbiter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic        RegWrite,
    output logic [4:0]  rd,
    output logic [31:0] Write_Data,
    input  logic [4:0]  q_rs,
    output logic        q_pending
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // Reject depths the power-of-two pointer wrap cannot handle.
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIM < 1) begin : g_bad_config
        $error("wb_write_arbiter: DEPTH must be a power of two in 2..16 and STARVE_LIM >= 1");
    end

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ld_ent_t;

    ld_ent_t         mem [DEPTH];
    ld_ent_t         head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            alu_win;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    // No pass-through when full: a same-cycle pop does not open a slot.
    assign ld_ready = reset && !full;
    // Loads to x0 complete the handshake but never occupy a slot.
    assign push     = ld_valid && ld_ready && (ld_rd != 5'd0);
    assign head     = mem[rd_ptr];

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] starved;
    logic          guard_fire;

    // Once the head has waited STARVE_LIM ALU-won cycles, it takes the port and the ALU holds.
    assign guard_fire = (starved == SW'(STARVE_LIM)) && !empty;
    assign alu_stall  = reset && guard_fire;

    // Count consecutive cycles the ALU beats a waiting load; any pop or an empty FIFO clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starved <= '0;
        end else if (pop || empty) begin
            starved <= '0;
        end else if (alu_win && (starved != SW'(STARVE_LIM))) begin
            starved <= starved + SW'(1);
        end
    end
`else
    assign alu_stall = 1'b0;
`endif

    // ALU has absolute priority unless stalled; otherwise the FIFO head drains.
    assign alu_win = alu_valid && !alu_stall;
    assign pop     = !alu_win && !empty;

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: ld_rd, dat: ld_data};
    end

    // Hazard query: match q_rs against every occupied slot, never against x0.
    always_comb begin
        logic [PW-1:0] offs;
        q_pending = 1'b0;
        offs      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs = PW'(i) - rd_ptr;
            if ((CW'(offs) < count) && (mem[i].rd == q_rs) && (q_rs != 5'd0)) begin
                q_pending = 1'b1;
            end
        end
    end

    // Register-file write port; an ALU write to x0 is consumed but suppressed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            RegWrite   <= 1'b0;
            rd         <= '0;
            Write_Data <= '0;
        end else if (alu_win) begin
            RegWrite   <= (alu_rd != 5'd0);
            rd         <= alu_rd;
            Write_Data <= alu_data;
        end else if (pop) begin
            RegWrite   <= 1'b1;
            rd         <= head.rd;
            Write_Data <= head.dat;
        end else begin
            RegWrite   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the write-back rules.
// Builds with or without WB_STARVE_GUARD_EN.
module tb_wb_write_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] Write_Data;
    logic [4:0]  q_rs;
    logic        q_pending;

    always #5 clk = ~clk;

    wb_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .Write_Data (Write_Data),
        .q_rs       (q_rs),
        .q_pending  (q_pending)
    );

    // Reference model state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        mq[$];
    int          starve;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    bit          e_full_chk;
    bit          last_stall;

    int n_chk;
    int n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check combinational outputs, advance the model,
    // clock the DUT and check the registered write port.
    task automatic cycle(input bit rn, input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input logic [4:0] qrs);
        bit x_ready;
        bit x_stall;
        bit x_pend;
        bit alu_takes;
        bit popped;
        reset     = rn;
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = adat;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldat;
        q_rs      = qrs;
        #1;
        x_ready = rn && (mq.size() < DEPTH);
`ifdef WB_STARVE_GUARD_EN
        x_stall = rn && (mq.size() != 0) && (starve == STARVE_LIM);
`else
        x_stall = 1'b0;
`endif
        x_pend = 1'b0;
        foreach (mq[i]) begin
            if (qrs != 5'd0 && mq[i].rd == qrs) x_pend = 1'b1;
        end
        check("ld_ready", 32'(ld_ready), 32'(x_ready));
        check("alu_stall", 32'(alu_stall), 32'(x_stall));
        check("q_pending", 32'(q_pending), 32'(x_pend));
        last_stall = av && x_stall;

        if (!rn) begin
            mq.delete();
            starve     = 0;
            e_we       = 1'b0;
            e_rd       = '0;
            e_wd       = '0;
            e_full_chk = 1'b1;
        end else begin
            e_full_chk = 1'b0;
            alu_takes  = av && !x_stall;
            popped     = !alu_takes && (mq.size() != 0);
            if (alu_takes) begin
                e_we = (ard != 5'd0);
                e_rd = ard;
                e_wd = adat;
            end else if (popped) begin
                e_we = 1'b1;
                e_rd = mq[0].rd;
                e_wd = mq[0].dat;
            end else begin
                e_we = 1'b0;
            end
            if (popped || mq.size() == 0) starve = 0;
            else if (alu_takes && starve < STARVE_LIM) starve++;
            if (popped) void'(mq.pop_front());
            if (lv && x_ready && lrd != 5'd0) mq.push_back('{rd: lrd, dat: ldat});
        end

        @(posedge clk);
        #1;
        check("RegWrite", 32'(RegWrite), 32'(e_we));
        if (e_we || e_full_chk) begin
            check("rd", 32'(rd), 32'(e_rd));
            check("Write_Data", Write_Data, e_wd);
        end
    endtask

    initial begin
        bit          r_av;
        logic [4:0]  r_ard;
        logic [31:0] r_adat;
        int          av_pct;

        n_chk      = 0;
        n_fail     = 0;
        starve     = 0;
        e_we       = 1'b0;
        e_rd       = '0;
        e_wd       = '0;
        e_full_chk = 1'b0;
        last_stall = 1'b0;
        reset      = 1'b0;
        alu_valid  = 1'b0;
        alu_rd     = '0;
        alu_data   = '0;
        ld_valid   = 1'b0;
        ld_rd      = '0;
        ld_data    = '0;
        q_rs       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_RegWrite", 32'(RegWrite), 32'd0);
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_Write_Data", Write_Data, 32'd0);
        check("reset_ld_ready", 32'(ld_ready), 32'd0);

        // Scenario 1: single ALU write
        cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 5'd0);
        check("s1_we", 32'(RegWrite), 32'd1);
        check("s1_rd", 32'(rd), 32'd5);
        check("s1_wd", Write_Data, 32'hDEADBEEF);

        // Scenario 2: four loads drain in order with the ALU idle
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 0, 5'd0, 32'd0, 1, 5'(k), 32'(k * 17), 5'd0);
            if (k >= 2) check("s2_order", 32'(rd), 32'(k - 1));
        end
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        check("s2_last", 32'(rd), 32'd4);
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);

        // Scenario 3: ALU busy, FIFO fills, hazard query
        for (int k = 1; k <= 4; k++) begin
            cycle(1, 1, 5'(20 + k), 32'(1000 + k), 1, 5'(k), 32'(k * 17), (k == 4) ? 5'd3 : 5'd0);
        end
        check("s3_full_ready", 32'(ld_ready), 32'd0);
        check("s3_pend_hit", 32'(q_pending), 32'd1);
        cycle(1, 1, 5'd31, 32'h1234, 0, 5'd0, 32'd0, 5'd0);
        check("s3_pend_x0", 32'(q_pending), 32'd0);

        // Scenario 6: reset with three entries buffered
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        cycle(0, 0, 5'd0, 32'd0, 1, 5'd6, 32'd66, 5'd3);
        check("s6_we", 32'(RegWrite), 32'd0);
        check("s6_pend", 32'(q_pending), 32'd0);
        check("s6_ready", 32'(ld_ready), 32'd0);
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);
        check("s6_ready_after", 32'(ld_ready), 32'd1);
        check("s6_no_stale", 32'(RegWrite), 32'd0);
        repeat (3) cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);

        // Scenario 4: starvation guard
        cycle(1, 1, 5'd9, 32'hA1, 1, 5'd7, 32'h77, 5'd0);
        repeat (4) cycle(1, 1, 5'd9, 32'hA1, 0, 5'd0, 32'd0, 5'd0);
        cycle(1, 1, 5'd9, 32'hB2, 0, 5'd0, 32'd0, 5'd0);
`ifdef WB_STARVE_GUARD_EN
        check("s4_load_rd", 32'(rd), 32'd7);
        check("s4_load_wd", Write_Data, 32'h77);
        cycle(1, 1, 5'd9, 32'hB2, 0, 5'd0, 32'd0, 5'd0);
        check("s4_held_rd", 32'(rd), 32'd9);
        check("s4_held_wd", Write_Data, 32'hB2);
`else
        check("s4_alu_rd", 32'(rd), 32'd9);
        check("s4_alu_wd", Write_Data, 32'hB2);
`endif
        repeat (2) cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0);

        // Scenario 5: x0 traffic never writes and never occupies the FIFO
        repeat (4) cycle(1, 1, 5'd0, $urandom, 1, 5'd0, $urandom, 5'd0);
        check("s5_we", 32'(RegWrite), 32'd0);
        check("s5_ready", 32'(ld_ready), 32'd1);

        // Randomized traffic with shifting ALU load and occasional resets
        r_av   = 1'b0;
        r_ard  = '0;
        r_adat = '0;
        for (int i = 0; i < 3000; i++) begin
            case ((i / 500) % 3)
                0:       av_pct = 25;
                1:       av_pct = 60;
                default: av_pct = 95;
            endcase
            if (!last_stall) begin
                r_av   = ($urandom_range(0, 99) < av_pct);
                r_ard  = 5'($urandom_range(0, 31));
                r_adat = $urandom;
            end
            cycle(($urandom_range(0, 99) != 0), r_av, r_ard, r_adat,
                  ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, sets the load-return FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter STARVE_LIM, default 4, sets the consecutive blocked cycles before the starvation guard fires.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 alu_valid  input  1  ALU result offered this cycle.
REQ-006 alu_rd  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_stall  output  1  ALU result not accepted this cycle; ALU holds its inputs.
REQ-009 ld_valid  input  1  load return offered.
REQ-010 ld_ready  output  1  load return accepted when ld_valid and ld_ready are both high.
REQ-011 ld_rd  input  5  load destination register.
REQ-012 ld_data  input  32  load data.
REQ-013 RegWrite  output  1  register-file write enable, registered.
REQ-014 rd  output  5  register-file write address, registered.
REQ-015 Write_Data  output  32  register-file write data, registered.
REQ-016 q_rs  input  5  hazard query register index.
REQ-017 q_pending  output  1  high when any valid FIFO entry has rd equal to q_rs (combinational).

Function
REQ-018 The block SHALL drive the single register-file write port from two sources: ALU results (unbuffered) and load returns (buffered in a DEPTH-entry FIFO).
REQ-019 ld_ready SHALL equal "FIFO not full". There is no pass-through when full, even if a pop occurs in the same cycle.
REQ-020 A handshaken load with ld_rd==0 SHALL be accepted and discarded, never enqueued.
REQ-021 Each cycle, exactly one source SHALL win: ALU if alu_valid && !alu_stall, else the FIFO head if non-empty, else none.
REQ-022 The winner SHALL appear on RegWrite/rd/Write_Data at the next rising edge (latency 1). RegWrite SHALL be 0 in any cycle with no winner.
REQ-023 An ALU winner with alu_rd==0 SHALL produce RegWrite=0 and SHALL still count as accepted.
REQ-024 A FIFO pop and a push in the same cycle SHALL leave the count unchanged, and the entries SHALL keep order.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH. The count SHALL range 0..DEPTH.
REQ-026 q_pending SHALL be 0 when q_rs==0 or the FIFO is empty.
REQ-027 The starved counter SHALL increment in each cycle where the FIFO is non-empty and the ALU wins. It SHALL clear on any FIFO pop or when the FIFO is empty, and saturate at STARVE_LIM.
REQ-028 Load returns SHALL write the register file in acceptance order.

Reset
REQ-029 While reset==0 at a rising edge, the block SHALL empty the FIFO, zero both pointers and the starved counter, and set RegWrite=0, rd=0, Write_Data=0.
REQ-030 During reset, ld_ready and alu_stall SHALL be 0. The cycle after reset deasserts, ld_ready SHALL be 1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered loads without issuing them.

Configuration
REQ-032 Macro WB_STARVE_GUARD_EN, when defined: when the starved counter equals STARVE_LIM and the FIFO is non-empty, alu_stall SHALL be 1 for that cycle, the FIFO head SHALL win, and the counter SHALL clear.
REQ-033 Macro WB_STARVE_GUARD_EN, when undefined: alu_stall SHALL be constant 0, the ALU SHALL always win, and the starved counter SHALL be omitted.

Verification
REQ-034 Scenario 1: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF, no loads -> next cycle RegWrite=1, rd=5, Write_Data=0xDEADBEEF.
REQ-035 Scenario 2: push 4 loads (rd 1..4, data 0x11..0x44) with alu_valid=0 -> ld_ready stays 1; writes to rd 1,2,3,4 appear in order on consecutive cycles.
REQ-036 Scenario 3: alu_valid=1 continuously, push 4 loads -> ld_ready=0 after the 4th; q_rs=3 gives q_pending=1; q_rs=0 gives q_pending=0.
REQ-037 Scenario 4 (guard on): FIFO non-empty, alu_valid=1 for 4 cycles -> 5th cycle alu_stall=1 and the load is written; the following cycle the held ALU result is written. With the guard off, no load is written while alu_valid=1.
REQ-038 Scenario 5: ld_rd=0 and alu_rd=0 traffic -> RegWrite never 1 and the FIFO count unchanged.
REQ-039 Scenario 6: reset=0 with 3 entries buffered -> next cycle RegWrite=0, q_pending=0, ld_ready=0; after release, no stale writes occur.
